// File: rtl/iter_arith_pkg.sv
// Shared types for the iterative arithmetic unit.
// Op codes, FSM states and the op field width.
package iter_arith_pkg;
  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    ADDSUB,
    MUL,
    DIV,
    DONE
  } state_e;
endpackage

// File: rtl/iter_arith_if.sv
// Operand/result handshake bundle for iter_arith_unit.
// master drives operands and out_ready; slave is the unit.
interface iter_arith_if
  import iter_arith_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [OP_W-1:0]    op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               carry;
  logic               overflow;
  logic               div_zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result,
    input  carry, overflow, div_zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result,
    output carry, overflow, div_zero
  );
endinterface

// File: rtl/iter_arith_unit_addsub.sv
// Ripple-carry adder with mode-inverted B and mode carry-in.
// Used for ADD/SUB and for the multiplier accumulate.
module addsub_w #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] yy;

  always_comb begin
    yy   = y ^ {WIDTH{sub}};
    sum  = '0;
    c    = '0;
    c[0] = sub;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]   = x[i] ^ yy[i] ^ c[i];
      c[i+1]   = (x[i] & yy[i]) | (c[i] & (x[i] ^ yy[i]));
    end
  end

  assign carry    = c[WIDTH];
  assign overflow = c[WIDTH] ^ c[WIDTH-1];
endmodule

// File: rtl/iter_arith_unit.sv
// Multi-cycle ADD/SUB/MUL/DIV unit, one bit per cycle for MUL/DIV.
// Divider is built only when ITER_ARITH_DIV_EN is defined.
module iter_arith_unit
  import iter_arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic       clk,
  input logic       rst,
  iter_arith_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               dz_q, dz_d;

  logic [WIDTH-1:0]   ax, ay, asum;
  logic               asub, acry, aovf;
  logic               last;
  op_e                op;

  assign op   = op_e'(bus.op);
  assign last = (cnt_q == CW'(WIDTH - 1));

  addsub_w #(.WIDTH(WIDTH)) u_add (
    .x        (ax),
    .y        (ay),
    .sub      (asub),
    .sum      (asum),
    .carry    (acry),
    .overflow (aovf)
  );

  // MUL accumulates into the high half; otherwise the bus operands feed it
  always_comb begin
    ax   = bus.a;
    ay   = bus.b;
    asub = (op == OP_SUB);
    if (state_q == MUL) begin
      ax   = res_q[2*WIDTH-1:WIDTH];
      ay   = res_q[0] ? opnd_q : '0;
      asub = 1'b0;
    end
  end

`ifdef ITER_ARITH_DIV_EN
  logic [WIDTH:0] rsh, trial;
  assign rsh   = {res_q[2*WIDTH-1:WIDTH], res_q[WIDTH-1]};
  assign trial = rsh - {1'b0, opnd_q};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          cnt_d   = '0;
          unique case (op)
            OP_ADD, OP_SUB: begin
              res_d   = {{WIDTH{1'b0}}, asum};
              carry_d = acry;
              ovf_d   = aovf;
              state_d = DONE;
            end
            OP_MUL: begin
              opnd_d  = bus.a;
              res_d   = {{WIDTH{1'b0}}, bus.b};
              state_d = MUL;
            end
            OP_DIV: begin
`ifdef ITER_ARITH_DIV_EN
              opnd_d = bus.b;
              if (bus.b == '0) begin
                res_d   = {bus.a, {WIDTH{1'b1}}};
                dz_d    = 1'b1;
                state_d = DONE;
              end else begin
                res_d   = {{WIDTH{1'b0}}, bus.a};
                state_d = DIV;
              end
`else
              res_d   = '0;
              dz_d    = 1'b1;
              state_d = DONE;
`endif
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        res_d = {acry, asum, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (last) state_d = DONE;
      end
`ifdef ITER_ARITH_DIV_EN
      // res_q holds {remainder, dividend/quotient}
      DIV: begin
        if (trial[WIDTH])
          res_d = {rsh[WIDTH-1:0], res_q[WIDTH-2:0], 1'b0};
        else
          res_d = {trial[WIDTH-1:0], res_q[WIDTH-2:0], 1'b1};
        cnt_d = cnt_q + CW'(1);
        if (last) state_d = DONE;
      end
`endif
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_iter_arith_unit.sv
// Randomised and directed bench for iter_arith_unit (WIDTH=16).
// Expected values come from a plain-arithmetic model.
module tb_iter_arith_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;

  iter_arith_if #(.WIDTH(16)) bus ();

  iter_arith_unit #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o,
                                input logic [15:0] x, y,
                                output logic [31:0] r,
                                output logic c, v, dz,
                                output int lat);
    logic [16:0] s;
    r = '0; c = 1'b0; v = 1'b0; dz = 1'b0; lat = 1;
    s = '0;
    case (o)
      2'd0: begin
        s = {1'b0, x} + {1'b0, y};
        r = {16'h0, s[15:0]};
        c = s[16];
        v = (x[15] == y[15]) && (s[15] != x[15]);
      end
      2'd1: begin
        s = {1'b0, x} + {1'b0, ~y} + 17'd1;
        r = {16'h0, s[15:0]};
        c = s[16];
        v = (x[15] != y[15]) && (s[15] != x[15]);
      end
      2'd2: begin
        r   = 32'(x) * 32'(y);
        lat = 17;
      end
      default: begin
`ifdef ITER_ARITH_DIV_EN
        if (y == 16'h0) begin
          r  = {x, 16'hFFFF};
          dz = 1'b1;
        end else begin
          r   = {x % y, x / y};
          lat = 17;
        end
`else
        dz = 1'b1;
`endif
      end
    endcase
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [15:0] x, y,
                       input int hold, input bit noisy);
    logic [31:0] er;
    logic        ec, ev, ed;
    int          el, n;
    model(o, x, y, er, ec, ev, ed, el);
    @(negedge clk);
    chk("in_ready", bus.in_ready, 1);
    bus.op = o; bus.a = x; bus.b = y;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = noisy;
    if (noisy) begin
      bus.a  = 16'($urandom);
      bus.b  = 16'($urandom);
      bus.op = 2'($urandom);
    end
    n = 1;
    @(negedge clk);
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(el));
    chk("result", bus.result, er);
    chk("carry", bus.carry, ec);
    chk("overflow", bus.overflow, ev);
    chk("div_zero", bus.div_zero, ed);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_result", bus.result, er);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    chk("idle_ready", bus.in_ready, 1);
    chk("idle_valid", bus.out_valid, 0);
  endtask

  task automatic abort_mul();
    @(negedge clk);
    bus.op = 2'd2; bus.a = 16'h1234; bus.b = 16'hABCD;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", bus.in_ready, 1);
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_result", bus.result, 0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [1:0]  ro;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flags", {bus.carry, bus.overflow, bus.div_zero}, 0);

    do_op(2'd0, 16'hFFFF, 16'h0001, 0, 1'b0);
    do_op(2'd1, 16'h8000, 16'h0001, 0, 1'b0);
    do_op(2'd2, 16'hFFFF, 16'hFFFF, 5, 1'b1);
`ifdef ITER_ARITH_DIV_EN
    do_op(2'd3, 16'd1000, 16'd7, 2, 1'b1);
    do_op(2'd3, 16'd1000, 16'd0, 1, 1'b0);
`else
    do_op(2'd3, 16'd10, 16'd2, 1, 1'b0);
`endif
    do_op(2'd2, 16'd3, 16'd5, 0, 1'b0);
    abort_mul();
    do_op(2'd0, 16'd3, 16'd4, 0, 1'b0);
    do_op(2'd0, 16'h7FFF, 16'h0001, 0, 1'b0);
    do_op(2'd1, 16'h0000, 16'h0001, 0, 1'b0);
    do_op(2'd2, 16'h0000, 16'hBEEF, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 5))
        0: rb = 16'h0;
        1: ra = 16'hFFFF;
        2: rb = 16'h8000;
        3: rb = 16'($urandom_range(1, 15));
        default: ;
      endcase
      do_op(ro, ra, rb, int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
